// File: rtl/remote_comm_pkg.sv
// Shared constants and state encodings for the remote_comm robot command link.
package remote_comm_pkg;

  localparam int BAUD_DIV_DEFAULT = 2604;
  localparam int FRAME_BITS       = 10;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HI,
    WAIT_HI,
    SEND_LO,
    WAIT_LO
  } cmdState_e;

  typedef enum logic {
    TX_IDLE,
    TX_BUSY
  } txState_e;

  typedef enum logic {
    RX_IDLE,
    RX_BUSY
  } rxState_e;

endpackage

// File: rtl/remote_comm_uart.sv
// 8N1 UART transmitter and receiver at BAUD_DIV clocks per bit.
// The two halves share only clock and reset and run independently of each other.
module uart
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy
);

  localparam int            CW        = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [3:0]    STOP_IDX  = 4'(FRAME_BITS - 1);

  txState_e      r_txState;
  txState_e      w_txNext;
  logic [CW-1:0] r_txBaud;
  logic [3:0]    r_txBit;
  logic [9:0]    r_txShift;
  logic          w_txBitEnd;

  assign w_txBitEnd = (r_txState == TX_BUSY) && (r_txBaud == BAUD_LAST);
  assign tx_done    = w_txBitEnd && (r_txBit == STOP_IDX);
  assign TX         = r_txShift[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_txState <= TX_IDLE;
    else     r_txState <= w_txNext;
  end

  always_comb begin
    w_txNext = r_txState;
    case (r_txState)
      TX_IDLE: if (trmt)    w_txNext = TX_BUSY;
      TX_BUSY: if (tx_done) w_txNext = TX_IDLE;
      default:              w_txNext = TX_IDLE;
    endcase
  end

  // The shift register fills with ones, so TX rests high after a frame and after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_txShift <= '1;
      r_txBaud  <= '0;
      r_txBit   <= '0;
    end else if (r_txState == TX_IDLE) begin
      if (trmt) begin
        r_txShift <= {1'b1, tx_data, 1'b0};
        r_txBaud  <= '0;
        r_txBit   <= '0;
      end
    end else if (w_txBitEnd) begin
      r_txShift <= {1'b1, r_txShift[9:1]};
      r_txBaud  <= '0;
      r_txBit   <= r_txBit + 4'd1;
    end else begin
      r_txBaud <= r_txBaud + 1'b1;
    end
  end

  rxState_e      r_rxState;
  rxState_e      w_rxNext;
  logic          r_rxSync1;
  logic          r_rxSync2;
  logic          r_rxPrev;
  logic [CW-1:0] r_rxBaud;
  logic [3:0]    r_rxBit;
  logic [7:0]    r_rxShift;
  logic          w_rxStart;
  logic          w_rxSample;
  logic          w_rxAbort;
  logic          w_rxDone;

  assign w_rxStart  = (r_rxState == RX_IDLE) && r_rxPrev && !r_rxSync2;
  assign w_rxSample = (r_rxState == RX_BUSY) && (r_rxBaud == '0);
  assign w_rxAbort  = w_rxSample && (r_rxBit == 4'd0) && r_rxSync2;
  assign w_rxDone   = w_rxSample && (r_rxBit == STOP_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rxState <= RX_IDLE;
    else     r_rxState <= w_rxNext;
  end

  // A start bit that reads high at its mid-bit sample was a glitch and is dropped.
  always_comb begin
    w_rxNext = r_rxState;
    case (r_rxState)
      RX_IDLE: if (w_rxStart)             w_rxNext = RX_BUSY;
      RX_BUSY: if (w_rxAbort || w_rxDone) w_rxNext = RX_IDLE;
      default:                            w_rxNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxSync1 <= 1'b1;
      r_rxSync2 <= 1'b1;
      r_rxPrev  <= 1'b1;
    end else begin
      r_rxSync1 <= RX;
      r_rxSync2 <= r_rxSync1;
      r_rxPrev  <= r_rxSync2;
    end
  end

  // First sample lands half a bit after the detected edge, then once per bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rxBaud  <= '0;
      r_rxBit   <= '0;
      r_rxShift <= '0;
    end else if (w_rxStart) begin
      r_rxBaud <= HALF_LAST;
      r_rxBit  <= '0;
    end else if (w_rxSample) begin
      r_rxBaud <= BAUD_LAST;
      r_rxBit  <= r_rxBit + 4'd1;
      if (r_rxBit != 4'd0 && r_rxBit != STOP_IDX)
        r_rxShift <= {r_rxSync2, r_rxShift[7:1]};
    end else if (r_rxState == RX_BUSY) begin
      r_rxBaud <= r_rxBaud - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= 8'h00;
      rx_rdy  <= 1'b0;
    end else if (w_rxDone) begin
      rx_data <= r_rxShift;
      rx_rdy  <= 1'b1;
    end else if (clr_rx_rdy || w_rxStart) begin
      rx_rdy <= 1'b0;
    end
  end

endmodule

// File: rtl/remote_comm.sv
// Sends a 16-bit command to the robot as two UART bytes, high byte first,
// and exposes the most recent response byte received from it.
module remote_comm
  import remote_comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        send_cmd,
  output logic        cmd_sent,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_rx_rdy
);

  cmdState_e   r_state;
  cmdState_e   w_nextState;
  logic [15:0] r_cmd;
  logic        r_cmdSent;
  logic        w_trmt;
  logic [7:0]  w_txData;
  logic        w_txDone;
  logic        w_accept;

  assign w_accept = (r_state == IDLE) && send_cmd;
  assign cmd_sent = r_cmdSent;

  uart #(.BAUD_DIV(BAUD_DIV)) uUart (
    .clk       (clk),
    .rst       (rst),
    .trmt      (w_trmt),
    .tx_data   (w_txData),
    .tx_done   (w_txDone),
    .TX        (TX),
    .RX        (RX),
    .rx_data   (resp),
    .rx_rdy    (resp_rdy),
    .clr_rx_rdy(clr_rx_rdy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_trmt      = 1'b0;
    w_txData    = r_cmd[15:8];
    case (r_state)
      IDLE:    if (send_cmd) w_nextState = SEND_HI;
      SEND_HI: begin
        w_trmt      = 1'b1;
        w_nextState = WAIT_HI;
      end
      WAIT_HI: if (w_txDone) w_nextState = SEND_LO;
      SEND_LO: begin
        w_trmt      = 1'b1;
        w_txData    = r_cmd[7:0];
        w_nextState = WAIT_LO;
      end
      WAIT_LO: if (w_txDone) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Requests arriving mid-command never reach the holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd     <= 16'h0000;
      r_cmdSent <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cmd     <= cmd;
        r_cmdSent <= 1'b0;
      end else if (r_state == WAIT_LO && w_txDone) begin
        r_cmdSent <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_remote_comm.sv
// Scoreboard bench for remote_comm: serial monitors decode TX and watch resp_rdy,
// popping expected bytes queued by the directed stimulus.
module tb_remote_comm;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rxDrive = 1'b1;
  logic        loopback = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        send_cmd = 1'b0;
  logic        clr_rx_rdy = 1'b0;
  logic        RX;
  logic        TX;
  logic        cmd_sent;
  logic [7:0]  resp;
  logic        resp_rdy;

  int checks = 0;
  int errors = 0;
  int cmdSentRises = 0;
  int cycleCnt = 0;

  logic [7:0] txExpQ[$];
  logic [7:0] rxExpQ[$];

  assign RX = loopback ? TX : rxDrive;

  remote_comm #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .TX        (TX),
    .cmd       (cmd),
    .send_cmd  (send_cmd),
    .cmd_sent  (cmd_sent),
    .resp      (resp),
    .resp_rdy  (resp_rdy),
    .clr_rx_rdy(clr_rx_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] word);
    @(negedge clk);
    cmd      = word;
    send_cmd = 1'b1;
    @(negedge clk);
    send_cmd = 1'b0;
    cmd      = ~word;
  endtask

  task automatic sendRxFrame(input logic [7:0] b);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rxDrive = frame[i];
      repeat (BD - 1) @(negedge clk);
    end
  endtask

  task automatic waitCmdSent(input string name);
    int n;
    n = 0;
    while (!cmd_sent && n < 25 * BD) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, int'(cmd_sent), 1);
  endtask

  // TX decoder: samples each bit in its middle and scores the byte at the stop bit.
  initial begin
    bit         busy;
    int         cnt;
    int         idx;
    logic [7:0] byteVal;
    busy = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (TX == 1'b0) begin
          busy = 1'b1;
          cnt  = 0;
        end
      end else begin
        cnt++;
        if ((cnt % BD) == BD / 2) begin
          idx = cnt / BD;
          if (idx == 0) begin
            checkOutput("txStartBit", int'(TX), 0);
          end else if (idx <= 8) begin
            byteVal[idx-1] = TX;
          end else begin
            busy = 1'b0;
            checkOutput("txStopBit", int'(TX), 1);
            if (txExpQ.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL txUnexpected: got byte %0h, required none", byteVal);
            end else begin
              checkOutput("txByte", int'(byteVal), int'(txExpQ.pop_front()));
            end
          end
        end
      end
    end
  end

  // Response monitor: every rising resp_rdy must match the next queued byte.
  initial begin
    logic prevRdy;
    logic prevSent;
    prevRdy  = 1'b0;
    prevSent = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_rdy && !prevRdy) begin
        if (rxExpQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL respUnexpected: got resp %0h, required none", resp);
        end else begin
          checkOutput("respByte", int'(resp), int'(rxExpQ.pop_front()));
        end
      end
      if (cmd_sent && !prevSent) cmdSentRises++;
      prevRdy  = resp_rdy;
      prevSent = cmd_sent;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    int delta;
    int lat;
    int base;

    $display("[TB] reset state");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("resetTX", int'(TX), 1);
    checkOutput("resetCmdSent", int'(cmd_sent), 0);
    checkOutput("resetRespRdy", int'(resp_rdy), 0);
    checkOutput("resetResp", int'(resp), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] command 2001");
    txExpQ.push_back(8'h20);
    txExpQ.push_back(8'h01);
    t0 = cycleCnt;
    applyStimulus(16'h2001);
    checkOutput("cmdSentCleared", int'(cmd_sent), 0);
    lat = 0;
    while (TX && lat < 2) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("txStartLatency", int'(TX), 0);
    waitCmdSent("cmdSent2001");
    delta = cycleCnt - t0;
    checkOutput("cmdSentTiming", int'(delta >= 20 * BD && delta <= 20 * BD + 6), 1);

    $display("[TB] receive A5");
    rxExpQ.push_back(8'hA5);
    sendRxFrame(8'hA5);
    repeat (3) @(negedge clk);
    checkOutput("respRdySet", int'(resp_rdy), 1);
    clr_rx_rdy = 1'b1;
    @(negedge clk);
    clr_rx_rdy = 1'b0;
    checkOutput("respRdyCleared", int'(resp_rdy), 0);
    checkOutput("respHeld", int'(resp), 8'hA5);

    $display("[TB] short RX glitch");
    @(negedge clk);
    rxDrive = 1'b0;
    repeat (BD / 2 - 2) @(negedge clk);
    rxDrive = 1'b1;
    repeat (12 * BD) @(negedge clk);
    checkOutput("glitchNoRdy", int'(resp_rdy), 0);
    checkOutput("glitchRespHeld", int'(resp), 8'hA5);

    $display("[TB] busy send ignored");
    txExpQ.push_back(8'h12);
    txExpQ.push_back(8'h34);
    base = cmdSentRises;
    applyStimulus(16'h1234);
    repeat (3 * BD) @(negedge clk);
    applyStimulus(16'hFFFF);
    waitCmdSent("cmdSent1234");
    repeat (2 * BD) @(negedge clk);
    checkOutput("singleCmdSentRise", cmdSentRises - base, 1);
    checkOutput("cmdSentHeld", int'(cmd_sent), 1);

    $display("[TB] loopback 5A3C");
    loopback = 1'b1;
    txExpQ.push_back(8'h5A);
    txExpQ.push_back(8'h3C);
    rxExpQ.push_back(8'h5A);
    rxExpQ.push_back(8'h3C);
    applyStimulus(16'h5A3C);
    waitCmdSent("cmdSent5A3C");
    repeat (4) @(negedge clk);
    loopback = 1'b0;
    checkOutput("loopRxDrained", rxExpQ.size(), 0);
    checkOutput("loopResp", int'(resp), 8'h3C);
    checkOutput("loopRespRdy", int'(resp_rdy), 1);
    clr_rx_rdy = 1'b1;
    @(negedge clk);
    clr_rx_rdy = 1'b0;

    $display("[TB] reset mid-frame");
    applyStimulus(16'hC3A5);
    repeat (4 * BD + BD / 2) @(negedge clk);
    checkOutput("txBit4Low", int'(TX), 0);
    rst = 1'b1;
    #1;
    checkOutput("midResetTX", int'(TX), 1);
    checkOutput("midResetCmdSent", int'(cmd_sent), 0);
    checkOutput("midResetResp", int'(resp), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("afterResetTX", int'(TX), 1);
    txExpQ.push_back(8'h00);
    txExpQ.push_back(8'h01);
    base = cmdSentRises;
    applyStimulus(16'h0001);
    waitCmdSent("cmdSent0001");
    repeat (4 * BD) @(negedge clk);
    checkOutput("freshCmdSentRise", cmdSentRises - base, 1);
    checkOutput("noStrayResp", int'(resp_rdy), 0);

    checkOutput("txQueueEmpty", txExpQ.size(), 0);
    checkOutput("rxQueueEmpty", rxExpQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
